npc_fetch_ctrl: RTL and testbench
=================================

// Module: npc_fetch_ctrl
// PURPOSE
//  Fetch sequencer around the next-PC datapath. Owns the architectural PC register,
//  issues word fetches to instruction memory over a req/ack handshake, and hands each
//  instruction to decode over a valid/ready handshake. On consume it forwards decode's
//  NPC control code to the NPC unit and registers the returned next PC. It also handles
//  late redirects, bad fetch addresses and memory timeouts; a fault is sticky until reset.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset
//  IM_BASE    32'h0000_3000  lowest legal fetch address
//  IM_WORDS   4096           legal range is [IM_BASE, IM_BASE + 4*IM_WORDS)
//  TIMEOUT    255            max wait cycles in FETCH before fault (8-bit counter)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  reset          in   1   synchronous reset, active-low (0 = reset)
//  im_req         out  1   fetch request, held until im_ack
//  im_addr        out  32  fetch address (= pc), stable while im_req
//  im_ack         in   1   memory returns im_rdata this cycle
//  im_rdata       in   32  instruction word
//  instr_valid    out  1   instr/pc_out valid for decode
//  instr_ready    in   1   decode consumes when instr_valid & instr_ready
//  instr          out  32  fetched instruction
//  pc_out         out  32  PC of instr; pc4 out 32 = pc_out + 4
//  npc_ctrl_in    in   3   decode's next-PC code (001 br, 010 j, 100 jr, other seq)
//  npc_ctrl       out  3   code to NPC unit: npc_ctrl_in when consuming, else 3'b000
//  npc_in         in   32  next PC from NPC unit (combinational from npc_ctrl, pc)
//  redir_valid    in   1   late-stage redirect (1-cycle pulse)
//  redir_target   in   32  redirect address
//  fault          out  1   sticky fault flag; fault_pc out 32 = offending address
// BEHAVIOUR
//  Reset (reset==0 at edge): pc<=RESET_PC, state<=BOOT, im_req=0, instr_valid=0,
//   instr=0, fault=0, fault_pc=0, wait_cnt=0, redir_pend=0. Reset has top priority in every state.
//  States: BOOT, FETCH, HOLD, FAULT. All outputs registered except npc_ctrl/im_addr.
//  BOOT: one cycle, outputs idle; next FETCH. redir_valid here loads pc<=redir_target.
//  Address check on every pc load: addr[1:0]!=0 or outside range -> FAULT,
//   fault_pc<=addr, fault<=1; no request is issued for a bad address.
//  FETCH: im_req=1, im_addr=pc; wait_cnt increments each non-ack cycle.
//   im_ack & !redir_pend & !redir_valid: instr<=im_rdata, instr_valid<=1, wait_cnt<=0, ->HOLD.
//   redir_valid in FETCH: pc_next<=redir_target, redir_pend<=1; request still completes.
//   im_ack with redir_pend|redir_valid: data discarded, pc<=target, pend cleared, new FETCH
//    (im_req drops 1 cycle between requests; im_ack same cycle as redir_valid also discards).
//   wait_cnt==TIMEOUT without ack: FAULT, fault_pc<=pc.
//  HOLD: instr_valid=1, instr/pc_out stable until consumed (no bubbles, no duplicates).
//   consume: npc_ctrl=npc_ctrl_in that cycle; pc<=npc_in (checked), instr_valid<=0, ->FETCH.
//   redir_valid wins over consume in same cycle: instr dropped, pc<=redir_target, ->FETCH.
//  FAULT: im_req=0, instr_valid=0; ignores redirects and acks; exits only via reset.
//  Throughput: 1 instr per 2+L cycles (L = ack latency); pc4 = pc_out+4 mod 2^32.
//  Reset mid-fetch: request abandoned; memory must tolerate a dropped im_req.
// TESTING
//  1 reset low 2 cycles, release; ack after 1 cycle with 32'h3C01_1234 ->
//    im_addr=32'h3000, instr_valid=1, instr=32'h3C01_1234, pc_out=32'h3000, pc4=32'h3004.
//  2 consume with npc_ctrl_in=3'b001, npc_in=32'h0000_3010 -> npc_ctrl=3'b001 that cycle,
//    next im_addr=32'h3010; instr_ready held low 5 cycles -> instr unchanged, valid stays 1.
//  3 redir_valid target 32'h3100 in FETCH cycle 1, ack in cycle 3 -> that data never
//    appears on instr; next im_addr=32'h3100; redirect+consume same cycle -> redirect wins.
//  4 npc_in=32'h0000_3002 on consume -> fault=1, fault_pc=32'h3002, im_req stays 0;
//    npc_in=32'h0000_7000 (IM_WORDS=4096) -> fault, fault_pc=32'h7000.
//  5 no ack for TIMEOUT=255 cycles -> fault=1, fault_pc=pc; reset low then high -> BOOT,
//    pc=32'h3000, fault=0; reset asserted mid-FETCH -> im_req=0 next cycle.

Source files
------------

// File: rtl/npc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches over im_req/im_ack, presents one instruction at a time to decode.
// 2+L cycles per instruction; holds instr until decode accepts, late redirects discard in-flight data.
module npc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc4,
    input  logic [2:0]  npc_ctrl_in,
    output logic [2:0]  npc_ctrl,
    input  logic [31:0] npc_in,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redir_pend;
    logic [7:0]  wait_cnt;

    logic        ld_en;
    logic [31:0] ld_addr;
    logic        ld_req;
    logic        consume;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IM_BASE) && ({1'b0, a} < IM_END);
    endfunction

    assign im_addr  = pc;
    assign pc_out   = pc;
    assign npc_ctrl = consume ? npc_ctrl_in : 3'b000;

    // Every PC update funnels through one load path so the address check is never bypassed.
    always_comb begin
        ld_en   = 1'b0;
        ld_addr = pc;
        ld_req  = 1'b1;
        consume = 1'b0;
        case (state)
            BOOT: begin
                ld_en   = 1'b1;
                ld_addr = redir_valid ? redir_target : pc;
            end
            FETCH: begin
                if (!im_req) begin
                    ld_en = 1'b1;
                    if (redir_valid)
                        ld_addr = redir_target;
                end else if (im_ack && (redir_pend || redir_valid)) begin
                    ld_en   = 1'b1;
                    ld_addr = redir_valid ? redir_target : pc_next;
                    ld_req  = 1'b0;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    ld_en   = 1'b1;
                    ld_addr = redir_target;
                end else if (instr_ready) begin
                    consume = 1'b1;
                    ld_en   = 1'b1;
                    ld_addr = npc_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pc4         <= RESET_PC + 32'd4;
            pc_next     <= 32'd0;
            redir_pend  <= 1'b0;
            wait_cnt    <= 8'd0;
            im_req      <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (im_req) begin
                        if (im_ack) begin
                            wait_cnt   <= 8'd0;
                            redir_pend <= 1'b0;
                            if (!(redir_pend || redir_valid)) begin
                                instr       <= im_rdata;
                                instr_valid <= 1'b1;
                                im_req      <= 1'b0;
                                state       <= HOLD;
                            end
                        end else if (wait_cnt == TIMEOUT) begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            fault_pc <= pc;
                            im_req   <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (redir_valid) begin
                                pc_next    <= redir_target;
                                redir_pend <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (redir_valid || instr_ready)
                        instr_valid <= 1'b0;
                end
                default: ;
            endcase

            // A bad address never reaches im_addr: it goes straight to the sticky fault.
            if (ld_en) begin
                if (addr_ok(ld_addr)) begin
                    pc     <= ld_addr;
                    pc4    <= ld_addr + 32'd4;
                    state  <= FETCH;
                    im_req <= ld_req;
                end else begin
                    state    <= FAULT;
                    fault    <= 1'b1;
                    fault_pc <= ld_addr;
                    im_req   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
module tb_npc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc4;
    logic [2:0]  npc_ctrl_in;
    logic [2:0]  npc_ctrl;
    logic [31:0] npc_in;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        fault;
    logic [31:0] fault_pc;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    npc_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .pc_out(pc_out), .pc4(pc4),
        .npc_ctrl_in(npc_ctrl_in), .npc_ctrl(npc_ctrl), .npc_in(npc_in),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        im_ack       = 1'b0;
        im_rdata     = 32'd0;
        instr_ready  = 1'b0;
        npc_ctrl_in  = 3'b000;
        npc_in       = 32'd0;
        redir_valid  = 1'b0;
        redir_target = 32'd0;
    endtask

    // Acks the current request with data and records what decode must later see.
    task automatic ack_expect(input logic [31:0] data);
        exp_t e;
        e.instr  = data;
        e.pc     = im_addr;
        q.push_back(e);
        im_ack   = 1'b1;
        im_rdata = data;
        tick();
        im_ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if ({im_req, instr_valid, fault} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got req/vld/flt=%b want 000", {im_req, instr_valid, fault}); end
        checks++; if (instr !== 32'd0 || fault_pc !== 32'd0) begin errors++;
            $display("FAIL reset_regs: got instr=%h fault_pc=%h want 0/0", instr, fault_pc); end
        checks++; if (pc_out !== 32'h3000) begin errors++;
            $display("FAIL reset_pc: got %h want 00003000", pc_out); end
        reset = 1'b1;
        tick();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin errors++;
            $display("FAIL boot_fetch: got req=%b addr=%h want 1/00003000", im_req, im_addr); end
    endtask

    task automatic test_first_fetch();
        exp_t e;
        tick();
        ack_expect(32'h3C01_1234);
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL first_sb: got empty queue want entry"); end
        else begin
            e = q.pop_front();
            if ({instr_valid, instr, pc_out, pc4} !== {1'b1, e.instr, e.pc, e.pc + 32'd4}) begin errors++;
                $display("FAIL first_instr: got vld=%b instr=%h pc=%h pc4=%h want 1/%h/%h/%h",
                         instr_valid, instr, pc_out, pc4, e.instr, e.pc, e.pc + 32'd4); end
        end
    endtask

    task automatic test_stall_consume();
        exp_t e;
        logic stable;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid !== 1'b1 || instr !== 32'h3C01_1234 || im_req !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++;
            $display("FAIL stall_hold: got instr=%h vld=%b want 3c011234/1", instr, instr_valid); end
        instr_ready = 1'b1; npc_ctrl_in = 3'b001; npc_in = 32'h0000_3010;
        #1;
        checks++; if (npc_ctrl !== 3'b001) begin errors++;
            $display("FAIL consume_ctrl: got %b want 001", npc_ctrl); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({instr_valid, im_req, im_addr, npc_ctrl} !== {1'b0, 1'b1, 32'h3010, 3'b000}) begin errors++;
            $display("FAIL consume_next: got vld=%b req=%b addr=%h ctrl=%b want 0/1/00003010/000",
                     instr_valid, im_req, im_addr, npc_ctrl); end
        ack_expect(32'hAAAA_0001);
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stall_sb: got empty queue want entry"); end
        else begin
            e = q.pop_front();
            if ({instr_valid, instr, pc_out} !== {1'b1, e.instr, e.pc}) begin errors++;
                $display("FAIL seq_instr: got vld=%b instr=%h pc=%h want 1/%h/%h",
                         instr_valid, instr, pc_out, e.instr, e.pc); end
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        instr_ready = 1'b1; npc_in = 32'h0000_3014;
        tick();
        idle_inputs();
        redir_valid = 1'b1; redir_target = 32'h0000_3100;
        tick();
        idle_inputs();
        tick();
        im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        checks++; if ({instr_valid, im_req, im_addr} !== {1'b0, 1'b0, 32'h3100}) begin errors++;
            $display("FAIL redir_discard: got vld=%b req=%b addr=%h want 0/0/00003100", instr_valid, im_req, im_addr); end
        tick();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h3100) begin errors++;
            $display("FAIL redir_refetch: got req=%b addr=%h want 1/00003100", im_req, im_addr); end
        ack_expect(32'h1111_0000);
        // ack coincident with a redirect is discarded too
        instr_ready = 1'b1; npc_in = 32'h0000_3104;
        tick();
        idle_inputs();
        im_ack = 1'b1; im_rdata = 32'h0000_BAD0; redir_valid = 1'b1; redir_target = 32'h0000_3200;
        tick();
        idle_inputs();
        checks++; if ({instr_valid, im_req, im_addr} !== {1'b0, 1'b0, 32'h3200}) begin errors++;
            $display("FAIL redir_same_ack: got vld=%b req=%b addr=%h want 0/0/00003200", instr_valid, im_req, im_addr); end
        tick();
        ack_expect(32'h2222_0000);
        instr_ready = 1'b1; npc_ctrl_in = 3'b010; npc_in = 32'h0000_3300;
        redir_valid = 1'b1; redir_target = 32'h0000_3400;
        #1;
        checks++; if (npc_ctrl !== 3'b000) begin errors++;
            $display("FAIL redir_wins_ctrl: got %b want 000", npc_ctrl); end
        tick();
        idle_inputs();
        checks++; if ({instr_valid, im_req, im_addr} !== {1'b0, 1'b1, 32'h3400}) begin errors++;
            $display("FAIL redir_wins_addr: got vld=%b req=%b addr=%h want 0/1/00003400", instr_valid, im_req, im_addr); end
        ack_expect(32'h3333_0000);
        while (q.size() > 0 && q[0].pc != 32'h3400) begin
            e = q.pop_front();
            checks++;
            if (e.pc != 32'h3100 && e.pc != 32'h3200) begin errors++;
                $display("FAIL redir_sb: got stale entry pc=%h want 3100/3200", e.pc); end
        end
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL redir_sb_last: got empty queue want entry"); end
        else begin
            e = q.pop_front();
            if ({instr_valid, instr, pc_out} !== {1'b1, e.instr, e.pc}) begin errors++;
                $display("FAIL redir_instr: got vld=%b instr=%h pc=%h want 1/%h/%h",
                         instr_valid, instr, pc_out, e.instr, e.pc); end
        end
    endtask

    task automatic test_bad_addr();
        exp_t e;
        instr_ready = 1'b1; npc_in = 32'h0000_3002;
        tick();
        idle_inputs();
        checks++; if ({fault, im_req, fault_pc} !== {1'b1, 1'b0, 32'h3002}) begin errors++;
            $display("FAIL misalign: got flt=%b req=%b fault_pc=%h want 1/0/00003002", fault, im_req, fault_pc); end
        redir_valid = 1'b1; redir_target = 32'h0000_3000; im_ack = 1'b1;
        tick();
        tick();
        idle_inputs();
        checks++; if ({fault, im_req, instr_valid, fault_pc} !== {1'b1, 1'b0, 1'b0, 32'h3002}) begin errors++;
            $display("FAIL fault_sticky: got flt=%b req=%b vld=%b fault_pc=%h want 1/0/0/00003002",
                     fault, im_req, instr_valid, fault_pc); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (fault !== 1'b0 || pc_out !== 32'h3000) begin errors++;
            $display("FAIL fault_clear: got flt=%b pc=%h want 0/00003000", fault, pc_out); end
        tick();
        ack_expect(32'h4444_0000);
        void'(q.pop_front());
        instr_ready = 1'b1; npc_in = 32'h0000_6FFC;
        tick();
        idle_inputs();
        checks++; if ({fault, im_req, im_addr} !== {1'b0, 1'b1, 32'h6FFC}) begin errors++;
            $display("FAIL last_word: got flt=%b req=%b addr=%h want 0/1/00006ffc", fault, im_req, im_addr); end
        ack_expect(32'h5555_0000);
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL edge_sb: got empty queue want entry"); end
        else begin
            e = q.pop_front();
            if ({instr_valid, instr, pc_out, pc4} !== {1'b1, e.instr, e.pc, 32'h7000}) begin errors++;
                $display("FAIL edge_instr: got vld=%b instr=%h pc=%h pc4=%h want 1/%h/%h/00007000",
                         instr_valid, instr, pc_out, pc4, e.instr, e.pc); end
        end
        instr_ready = 1'b1; npc_in = 32'h0000_7000;
        tick();
        idle_inputs();
        checks++; if ({fault, im_req, fault_pc} !== {1'b1, 1'b0, 32'h7000}) begin errors++;
            $display("FAIL out_of_range: got flt=%b req=%b fault_pc=%h want 1/0/00007000", fault, im_req, fault_pc); end
    endtask

    task automatic test_timeout();
        int n;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n !== 256 || fault_pc !== 32'h3000) begin errors++;
            $display("FAIL timeout: got cycles=%0d fault_pc=%h want 256/00003000", n, fault_pc); end
        reset = 1'b0;
        tick();
        checks++; if ({fault, im_req, pc_out} !== {1'b0, 1'b0, 32'h3000}) begin errors++;
            $display("FAIL timeout_reset: got flt=%b req=%b pc=%h want 0/0/00003000", fault, im_req, pc_out); end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (im_req !== 1'b0) begin errors++;
            $display("FAIL reset_midfetch: got req=%b want 0", im_req); end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_consume();
        test_redirect();
        test_bad_addr();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
